usb_control_mul_arbiter: RTL and testbench

Shares one pipelined 32x32 multiplier/shifter cell, `usb_control_cpu_mult_cell`, between NUM_REQ requesters inside the USB control subsystem. Each requester has a valid/ready request port. The block arbitrates requests round-robin and drives the cell's E-stage operands and M/A-stage enables. It aligns the M-stage rotate/shift flags, tracks requester IDs through the two-stage pipe, and returns results on one shared response port with backpressure.

---
 rtl/usb_control_mul_arbiter.sv | 107 ++++++++++
 tb/tb_usb_control_mul_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_control_mul_arbiter.sv
// Round-robin arbiter that shares one two-stage multiplier/shifter cell among NUM_REQ requesters.
// Tracks requester IDs and op flags through the cell pipe and returns results on one response port.
module usb_control_mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_src1,
  input  logic [32*NUM_REQ-1:0]   req_src2,
  input  logic [2*NUM_REQ-1:0]    req_sign,
  input  logic [2*NUM_REQ-1:0]    req_op,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [31:0]             resp_data,
  output logic [31:0]             cell_src1,
  output logic [31:0]             cell_src2,
  output logic                    cell_src1_signed,
  output logic                    cell_src2_signed,
  output logic                    cell_m_en,
  output logic                    cell_a_en,
  output logic                    cell_rotate,
  output logic                    cell_shift_right,
  output logic                    cell_reset_n,
  input  logic [31:0]             cell_result
);

  logic            m_vld_q, a_vld_q;
  logic [ID_W-1:0] m_id_q, a_id_q, rr_ptr_q;
  logic [1:0]      m_op_q;

  logic            stall;
  logic            found;
  logic            grant;
  int              win_idx;
  int              sel_idx;
  logic [ID_W-1:0] win_id;
  logic [1:0]      win_op;

  assign stall = a_vld_q & ~resp_ready;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    win_idx = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  assign grant   = found & ~stall & ~reset;
  assign win_id  = ID_W'(win_idx);
  // Without a winner the E-stage mux parks on rr_ptr; m_vld loads 0 so the values are unused.
  assign sel_idx = found ? win_idx : int'(rr_ptr_q);

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win_idx] = 1'b1;
  end

  assign cell_src1        = req_src1[32*sel_idx +: 32];
  assign cell_src2        = req_src2[32*sel_idx +: 32];
  assign cell_src1_signed = req_sign[2*sel_idx];
  assign cell_src2_signed = req_sign[2*sel_idx+1];
  assign win_op           = req_op[2*sel_idx +: 2];

  assign cell_m_en        = reset | ~stall;
  assign cell_a_en        = reset | ~stall;
  assign cell_reset_n     = ~reset;
  assign cell_rotate      = m_op_q[1] & m_vld_q & ~reset;
  assign cell_shift_right = m_op_q[0] & m_vld_q & ~reset;

  assign resp_valid = a_vld_q & ~reset;
  assign resp_id    = a_id_q;
  assign resp_data  = cell_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_vld_q  <= 1'b0;
      a_vld_q  <= 1'b0;
      m_id_q   <= '0;
      a_id_q   <= '0;
      m_op_q   <= 2'b00;
      rr_ptr_q <= '0;
    end else if (!stall) begin
      m_vld_q <= grant;
      m_id_q  <= win_id;
      m_op_q  <= win_op;
      a_vld_q <= m_vld_q;
      a_id_q  <= m_id_q;
      if (grant) begin
        rr_ptr_q <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_usb_control_mul_arbiter.sv
// Directed bench for usb_control_mul_arbiter with a small behavioural stand-in for the cell.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_usb_control_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_src1, req_src2;
  logic [2*NUM_REQ-1:0]  req_sign, req_op;
  logic                  resp_valid, resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_data;
  logic [31:0]           cell_src1, cell_src2;
  logic                  cell_src1_signed, cell_src2_signed;
  logic                  cell_m_en, cell_a_en, cell_rotate, cell_shift_right, cell_reset_n;
  logic [31:0]           cell_result;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  usb_control_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_src1         (req_src1),
    .req_src2         (req_src2),
    .req_sign         (req_sign),
    .req_op           (req_op),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_id          (resp_id),
    .resp_data        (resp_data),
    .cell_src1        (cell_src1),
    .cell_src2        (cell_src2),
    .cell_src1_signed (cell_src1_signed),
    .cell_src2_signed (cell_src2_signed),
    .cell_m_en        (cell_m_en),
    .cell_a_en        (cell_a_en),
    .cell_rotate      (cell_rotate),
    .cell_shift_right (cell_shift_right),
    .cell_reset_n     (cell_reset_n),
    .cell_result      (cell_result)
  );

  // Cell stand-in: low 32 bits of the product, inverted when a rotate/shift flag is seen in M.
  logic [31:0] e_a, e_b;
  logic        e_s1, e_s2;
  logic [63:0] prod;
  assign prod = {{32{e_s1 & e_a[31]}}, e_a} * {{32{e_s2 & e_b[31]}}, e_b};

  always @(posedge clk) begin
    if (!cell_reset_n) begin
      e_a <= '0; e_b <= '0; e_s1 <= 1'b0; e_s2 <= 1'b0; cell_result <= '0;
    end else begin
      if (cell_m_en) begin
        e_a <= cell_src1; e_b <= cell_src2; e_s1 <= cell_src1_signed; e_s2 <= cell_src2_signed;
      end
      if (cell_a_en) cell_result <= (cell_rotate | cell_shift_right) ? ~prod[31:0] : prod[31:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] s, input logic [1:0] o);
    req_src1[32*i +: 32] = a;
    req_src2[32*i +: 32] = b;
    req_sign[2*i +: 2]   = s;
    req_op[2*i +: 2]     = o;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 4'hF; resp_ready = 1'b1;
    req_src1 = '0; req_src2 = '0; req_sign = '0; req_op = '0;
    tick();
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_m_en", 32'(cell_m_en), 32'h1);
    check("rst_cell_reset_n", 32'(cell_reset_n), 32'h0);
    tick();
    reset = 1'b0; req_valid = '0;

    // Single multiply from requester 2
    set_req(2, 32'd7, 32'd6, 2'b00, 2'b00); req_valid = 4'b0100; #1;
    check("mul_ready", 32'(req_ready), 32'h4);
    check("mul_c0_valid", 32'(resp_valid), 32'h0);
    tick(); req_valid = '0; #1;
    check("mul_c1_valid", 32'(resp_valid), 32'h0);
    tick(); #1;
    check("mul_c2_valid", 32'(resp_valid), 32'h1);
    check("mul_c2_id", 32'(resp_id), 32'h2);
    check("mul_c2_data", resp_data, 32'd42);
    tick(); #1;
    check("mul_c3_valid", 32'(resp_valid), 32'h0);

    // Signed multiply, rr_ptr=3 so requester 1 wins after wrap
    set_req(1, 32'hFFFF_FFFD, 32'd5, 2'b11, 2'b00); req_valid = 4'b0010; #1;
    check("sgn_ready", 32'(req_ready), 32'h2);
    check("sgn_src1", cell_src1, 32'hFFFF_FFFD);
    check("sgn_signed", {30'd0, cell_src2_signed, cell_src1_signed}, 32'h3);
    tick(); req_valid = '0;
    tick(); #1;
    check("sgn_id", 32'(resp_id), 32'h1);
    check("sgn_data", resp_data, 32'hFFFF_FFF1);

    // Op flag alignment: rotate+shift only during M
    set_req(1, 32'd3, 32'd4, 2'b00, 2'b11); req_valid = 4'b0010; #1;
    check("op_t_ready", 32'(req_ready), 32'h2);
    check("op_t_flags", {30'd0, cell_rotate, cell_shift_right}, 32'h0);
    tick(); req_valid = '0; #1;
    check("op_t1_flags", {30'd0, cell_rotate, cell_shift_right}, 32'h3);
    tick(); #1;
    check("op_t2_flags", {30'd0, cell_rotate, cell_shift_right}, 32'h0);
    check("op_t2_data", resp_data, 32'hFFFF_FFF3);

    // Round-robin fairness from reset, all requesters valid
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'(i + 1), 32'd10, 2'b00, 2'b00);
    req_valid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) req_valid = '0;
      #1;
      if (k < 8) check($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 2) begin
        check($sformatf("rr_valid_%0d", k), 32'(resp_valid), 32'h1);
        check($sformatf("rr_id_%0d", k), 32'(resp_id), 32'((k - 2) % 4));
        check($sformatf("rr_data_%0d", k), resp_data, 32'((((k - 2) % 4) + 1) * 10));
      end
      tick();
    end
    #1;
    check("rr_drain", 32'(resp_valid), 32'h0);

    // Backpressure: A (id0) then B (id1), stall 3 cycles on A
    set_req(0, 32'd2, 32'd3, 2'b00, 2'b00);
    set_req(1, 32'd4, 32'd5, 2'b00, 2'b00);
    set_req(2, 32'd7, 32'd1, 2'b00, 2'b00);
    req_valid = 4'b0001; #1;
    check("bp_a_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = 4'b0010; #1;
    check("bp_b_ready", 32'(req_ready), 32'h2);
    tick(); req_valid = 4'b0100; resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_stall_valid_%0d", k), 32'(resp_valid), 32'h1);
      check($sformatf("bp_stall_id_%0d", k), 32'(resp_id), 32'h0);
      check($sformatf("bp_stall_data_%0d", k), resp_data, 32'd6);
      check($sformatf("bp_stall_ready_%0d", k), 32'(req_ready), 32'h0);
      check($sformatf("bp_stall_men_%0d", k), 32'(cell_m_en), 32'h0);
      tick();
    end
    resp_ready = 1'b1; #1;
    check("bp_a_accept_id", 32'(resp_id), 32'h0);
    check("bp_a_accept_data", resp_data, 32'd6);
    check("bp_c_ready", 32'(req_ready), 32'h4);
    tick(); req_valid = '0; #1;
    check("bp_b_valid", 32'(resp_valid), 32'h1);
    check("bp_b_id", 32'(resp_id), 32'h1);
    check("bp_b_data", resp_data, 32'd20);
    tick(); #1;
    check("bp_c_id", 32'(resp_id), 32'h2);
    check("bp_c_data", resp_data, 32'd7);
    tick(); #1;
    check("bp_empty", 32'(resp_valid), 32'h0);

    // Reset mid-flight: rr_ptr=3, grant 3 then 0, then reset
    req_valid = 4'b1000; #1;
    check("rm_g3", 32'(req_ready), 32'h8);
    tick(); req_valid = 4'b0001; #1;
    check("rm_g0", 32'(req_ready), 32'h1);
    tick(); reset = 1'b1; req_valid = 4'hF; #1;
    check("rm_rst_ready", 32'(req_ready), 32'h0);
    check("rm_rst_valid", 32'(resp_valid), 32'h0);
    tick(); reset = 1'b0; req_valid = 4'b1110; #1;
    check("rm_post_valid", 32'(resp_valid), 32'h0);
    check("rm_post_ready", 32'(req_ready), 32'h2);
    tick(); req_valid = '0; #1;
    check("rm_post2_valid", 32'(resp_valid), 32'h0);
    tick(); #1;
    check("rm_new_valid", 32'(resp_valid), 32'h1);
    check("rm_new_id", 32'(resp_id), 32'h1);
    check("rm_new_data", resp_data, 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
